// File: rtl/snn_lif_layer_pkg.sv
// Shared fixed-point definitions for the LIF layer: signed Q4.12 format,
// saturating arithmetic helpers and the fixed-point constants of the model.
package snn_lif_layer_pkg;

  localparam int W    = 16;
  localparam int FRAC = 12;
  localparam int DW   = 8;

  typedef logic signed [W-1:0] fx_t;
  typedef logic signed [31:0]  acc_t;
  typedef logic [DW-1:0]       dly_t;

  localparam fx_t FX_MAX  = fx_t'(32767);
  localparam fx_t FX_MIN  = fx_t'(-32768);
  localparam fx_t FX_ZERO = fx_t'(0);
  localparam fx_t FX_ONE  = fx_t'(4096);  // FX(1.0)
  localparam fx_t FX_0_92 = fx_t'(3768);  // FX(0.92)
  localparam fx_t FX_0_88 = fx_t'(3604);  // FX(0.88)
  localparam fx_t FX_0_96 = fx_t'(3932);  // FX(0.96)
  localparam fx_t FX_0_90 = fx_t'(3686);  // FX(0.90)

  // Clamp a wide intermediate into the Q4.12 range.
  function automatic fx_t sat(input acc_t x);
    if (x > acc_t'(FX_MAX)) return FX_MAX;
    if (x < acc_t'(FX_MIN)) return FX_MIN;
    return fx_t'(x[W-1:0]);
  endfunction

  function automatic fx_t sat_add(input fx_t a, input fx_t b);
    return sat(acc_t'(a) + acc_t'(b));
  endfunction

  function automatic fx_t sat_sub(input fx_t a, input fx_t b);
    return sat(acc_t'(a) - acc_t'(b));
  endfunction

  // Full-width product, arithmetic shift back to Q4.12, then saturate.
  function automatic fx_t sat_mul(input fx_t a, input fx_t b);
    acc_t p;
    p = acc_t'(a) * acc_t'(b);
    return sat(p >>> FRAC);
  endfunction

  // Delays beyond the history depth are pinned to the deepest tap.
  function automatic dly_t clamp_delay(input dly_t d, input int max_d);
    if (int'(d) > max_d) return dly_t'(max_d);
    return d;
  endfunction

endpackage

// File: rtl/snn_lif_layer_neuron.sv
// Single leaky integrate-and-fire neuron (lif_neuron): excitatory and
// inhibitory conductances, leaky membrane, threshold/reset and refractory
// counter. All outputs are registered next-state values.
module snn_lif_layer_neuron
  import snn_lif_layer_pkg::*;
#(
  parameter fx_t G_DECAY_E  = FX_0_92,
  parameter fx_t G_DECAY_I  = FX_0_88,
  parameter fx_t V_TH       = FX_ONE,
  parameter fx_t V_RESET    = FX_ZERO,
  parameter fx_t V_REST     = FX_ZERO,
  parameter fx_t LEAK_A     = FX_0_96,
  parameter int  REFR_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] exc_in,
  input  logic signed [W-1:0] inh_in,
  output logic                spike,
  output logic signed [W-1:0] vmem,
  output logic signed [W-1:0] g_exc,
  output logic signed [W-1:0] g_inh,
  output logic signed [W-1:0] i_total
);

  localparam int RW = (REFR_TICKS < 2) ? 1 : $clog2(REFR_TICKS + 1);
  typedef logic [RW-1:0] refr_t;

  refr_t refr, refr_n;
  fx_t   ge_n, gi_n, it_n, v_leak, v_n;
  logic  spike_n;

  // Decay conductances, add new input, then integrate or hold in refractory
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise a path that skips the assignment infers a latch.
    v_n     = FX_ZERO;
    refr_n  = refr;
    spike_n = 1'b0;
    ge_n    = sat_add(sat_mul(g_exc, G_DECAY_E), exc_in);
    gi_n    = sat_add(sat_mul(g_inh, G_DECAY_I), inh_in);
    it_n    = sat_sub(ge_n, gi_n);
    v_leak  = sat_add(sat_add(V_REST, sat_mul(sat_sub(vmem, V_REST), LEAK_A)), it_n);
    if (refr != '0) begin
      v_n    = V_RESET;
      refr_n = refr - refr_t'(1);
    end else if (v_leak >= V_TH) begin
      v_n     = V_RESET;
      spike_n = 1'b1;
      refr_n  = refr_t'(REFR_TICKS);
    end else begin
      v_n = v_leak;
    end
  end

  // Neuron state register; synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      spike   <= 1'b0;
      vmem    <= V_REST;
      g_exc   <= FX_ZERO;
      g_inh   <= FX_ZERO;
      i_total <= FX_ZERO;
      refr    <= '0;
    end else begin
      spike   <= spike_n;
      vmem    <= v_n;
      g_exc   <= ge_n;
      g_inh   <= gi_n;
      i_total <= it_n;
      refr    <= refr_n;
    end
  end

endmodule

// File: rtl/snn_lif_layer.sv
// Fully connected LIF layer: per-synapse weight/delay memories, per-input
// spike history, synapse summation and one neuron instance per output.
// Optional on-line STDP learning is compiled in with the macro SNN_STDP_EN
// and then gated at run time by the STDP_ENABLE parameter.
module snn_lif_layer
  import snn_lif_layer_pkg::*;
#(
  parameter int  NUM_INPUTS  = 8,
  parameter int  NUM_NEURONS = 4,
  parameter int  MAX_DELAY   = 4,
  parameter logic [NUM_NEURONS*NUM_INPUTS*W-1:0]  W_INIT     = '0,
  parameter logic [NUM_NEURONS*NUM_INPUTS*DW-1:0] DELAY_INIT = '0,
  parameter fx_t G_DECAY_E   = FX_0_92,
  parameter fx_t G_DECAY_I   = FX_0_88,
  parameter fx_t V_TH        = FX_ONE,
  parameter fx_t V_RESET     = FX_ZERO,
  parameter fx_t V_REST      = FX_ZERO,
  parameter fx_t LEAK_A      = FX_0_96,
  parameter int  REFR_TICKS  = 4,
  parameter bit  STDP_ENABLE = 1'b0,
  localparam int NUM_SYN     = NUM_NEURONS * NUM_INPUTS,
  localparam int AW          = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_INPUTS-1:0]  pre_spikes,
  input  logic                   cfg_we,
  input  logic                   cfg_sel_delay,
  input  logic [AW-1:0]          cfg_addr,
  input  logic signed [W-1:0]    cfg_wdata,
  input  logic [DW-1:0]          cfg_delay,
  output logic [NUM_NEURONS-1:0] post_spikes,
  output logic signed [W-1:0]    post_vmem   [NUM_NEURONS],
  output logic signed [W-1:0]    dbg_exc     [NUM_NEURONS],
  output logic signed [W-1:0]    dbg_inh     [NUM_NEURONS],
  output logic signed [W-1:0]    dbg_i_total [NUM_NEURONS]
);

  typedef logic [MAX_DELAY-1:0] hist_t;

  fx_t              w_mem   [NUM_SYN];
  dly_t             d_mem   [NUM_SYN];
  hist_t            hist    [NUM_INPUTS];
  logic [NUM_SYN-1:0] arrived;
  acc_t             exc_acc [NUM_NEURONS];
  acc_t             inh_acc [NUM_NEURONS];
  fx_t              exc_in  [NUM_NEURONS];
  fx_t              inh_in  [NUM_NEURONS];
  logic             addr_ok;

  assign addr_ok = (int'(cfg_addr) < NUM_SYN);

  // Input spike history: bit j holds the sample taken j+1 edges ago
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!rst_n) hist[i] <= '0;
      else        hist[i] <= (hist[i] << 1) | hist_t'(pre_spikes[i]);
    end
  end

  // Select the arriving spike of each synapse by its delay tap
  always_comb begin
    arrived = '0;
    for (int s = 0; s < NUM_SYN; s++) begin
      if (d_mem[s] == '0) arrived[s] = pre_spikes[s % NUM_INPUTS];
      for (int j = 0; j < MAX_DELAY; j++) begin
        if (d_mem[s] == dly_t'(j + 1)) arrived[s] = hist[s % NUM_INPUTS][j];
      end
    end
  end

  // Split arrived weights into excitatory and inhibitory drive per neuron
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      exc_acc[n] = '0;
      inh_acc[n] = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (arrived[n*NUM_INPUTS + i]) begin
          if (w_mem[n*NUM_INPUTS + i] > FX_ZERO)
            exc_acc[n] = exc_acc[n] + acc_t'(w_mem[n*NUM_INPUTS + i]);
          else
            inh_acc[n] = inh_acc[n] - acc_t'(w_mem[n*NUM_INPUTS + i]);
        end
      end
      exc_in[n] = sat(exc_acc[n]);
      inh_in[n] = sat(inh_acc[n]);
    end
  end

`ifdef SNN_STDP_EN
  fx_t pre_trace  [NUM_SYN];
  fx_t post_trace [NUM_NEURONS];
  fx_t w_learn    [NUM_SYN];

  // Traces decay every edge and jump by one on their own spike
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SYN; s++) begin
      if (!rst_n) pre_trace[s] <= FX_ZERO;
      else pre_trace[s] <= sat_add(sat_mul(pre_trace[s], FX_0_90),
                                   arrived[s] ? FX_ONE : FX_ZERO);
    end
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (!rst_n) post_trace[n] <= FX_ZERO;
      else post_trace[n] <= sat_add(sat_mul(post_trace[n], FX_0_90),
                                    post_spikes[n] ? FX_ONE : FX_ZERO);
    end
  end

  // Potentiate on a post spike, depress on an arrived pre spike, bound to +-1
  always_comb begin
    for (int s = 0; s < NUM_SYN; s++) begin
      w_learn[s] = w_mem[s];
      if (post_spikes[s / NUM_INPUTS])
        w_learn[s] = sat_add(w_learn[s], pre_trace[s] >>> 4);
      if (arrived[s])
        w_learn[s] = sat_sub(w_learn[s], post_trace[s / NUM_INPUTS] >>> 4);
      if (w_learn[s] > FX_ONE)       w_learn[s] = FX_ONE;
      else if (w_learn[s] < -FX_ONE) w_learn[s] = -FX_ONE;
    end
  end
`else
  // Runtime enable has no effect when the learning hardware is not built.
  if (STDP_ENABLE) begin : g_stdp_not_built
  end
`endif

  // Weight/delay memories: reload on reset, learning update, then cfg write
  always_ff @(posedge clk) begin
    // NOTE: these memories are reset on purpose -- reset must restore the
    // initial table, so they stay flops rather than an unreset RAM.
    if (!rst_n) begin
      for (int s = 0; s < NUM_SYN; s++) begin
        w_mem[s] <= W_INIT[s*W +: W];
        d_mem[s] <= clamp_delay(DELAY_INIT[s*DW +: DW], MAX_DELAY);
      end
    end else begin
`ifdef SNN_STDP_EN
      if (STDP_ENABLE) begin
        for (int s = 0; s < NUM_SYN; s++) w_mem[s] <= w_learn[s];
      end
`endif
      if (cfg_we && addr_ok) begin
        if (cfg_sel_delay) d_mem[cfg_addr] <= clamp_delay(cfg_delay, MAX_DELAY);
        else               w_mem[cfg_addr] <= cfg_wdata;
      end
    end
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    snn_lif_layer_neuron #(
      .G_DECAY_E  (G_DECAY_E),
      .G_DECAY_I  (G_DECAY_I),
      .V_TH       (V_TH),
      .V_RESET    (V_RESET),
      .V_REST     (V_REST),
      .LEAK_A     (LEAK_A),
      .REFR_TICKS (REFR_TICKS)
    ) u_neuron (
      .clk     (clk),
      .rst_n   (rst_n),
      .exc_in  (exc_in[n]),
      .inh_in  (inh_in[n]),
      .spike   (post_spikes[n]),
      .vmem    (post_vmem[n]),
      .g_exc   (dbg_exc[n]),
      .g_inh   (dbg_inh[n]),
      .i_total (dbg_i_total[n])
    );
  end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Self-checking bench for snn_lif_layer: a cycle-indexed behavioural model
// of the layer, a per-cycle compare process, directed literal checks and a
// randomized phase with config writes, out-of-range addresses and resets.
module tb_snn_lif_layer;

  localparam int NI = 6;
  localparam int NN = 4;
  localparam int NS = NI * NN;   // 24 synapses, addresses 24..31 unused
  localparam int AW = 5;
  localparam int MAXD = 4;
  localparam int DE = 3768, DI = 3604, LEAK = 3932, VTH = 4096, REFR = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NI-1:0]        pre_spikes;
  logic                 cfg_we;
  logic                 cfg_sel_delay;
  logic [AW-1:0]        cfg_addr;
  logic signed [15:0]   cfg_wdata;
  logic [7:0]           cfg_delay;
  logic [NN-1:0]        post_spikes;
  logic signed [15:0]   post_vmem   [NN];
  logic signed [15:0]   dbg_exc     [NN];
  logic signed [15:0]   dbg_inh     [NN];
  logic signed [15:0]   dbg_i_total [NN];

  snn_lif_layer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pre_spikes   (pre_spikes),
    .cfg_we       (cfg_we),
    .cfg_sel_delay(cfg_sel_delay),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_delay    (cfg_delay),
    .post_spikes  (post_spikes),
    .post_vmem    (post_vmem),
    .dbg_exc      (dbg_exc),
    .dbg_inh      (dbg_inh),
    .dbg_i_total  (dbg_i_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_w [NS];
  int            m_d [NS];
  int            m_ge[NN], m_gi[NN], m_it[NN], m_v[NN], m_refr[NN];
  bit            m_spk[NN];
  logic [NI-1:0] in_at [0:8191];   // input vector seen at each edge
  int            edge_no = 0;
  int            last_rst = 0;
  bit            model_valid = 1'b0;
  int            spike_total = 0;

  function automatic int fsat(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic int fmul(input int a, input int b);
    longint p = longint'(a) * longint'(b);
    return fsat(p >>> 12);
  endfunction

  task automatic model_edge();
    edge_no++;
    if (!rst_n) begin
      last_rst = edge_no;
      in_at[edge_no] = '0;
      for (int s = 0; s < NS; s++) begin m_w[s] = 0; m_d[s] = 0; end
      for (int n = 0; n < NN; n++) begin
        m_ge[n] = 0; m_gi[n] = 0; m_it[n] = 0; m_v[n] = 0; m_refr[n] = 0; m_spk[n] = 0;
      end
    end else begin
      in_at[edge_no] = pre_spikes;
      for (int n = 0; n < NN; n++) begin
        longint exc = 0;
        longint inh = 0;
        int vn;
        for (int i = 0; i < NI; i++) begin
          int s = n * NI + i;
          int src = edge_no - m_d[s];
          if (src > last_rst && in_at[src][i]) begin
            if (m_w[s] > 0) exc += m_w[s];
            else            inh -= m_w[s];
          end
        end
        m_ge[n] = fsat(fmul(m_ge[n], DE) + fsat(exc));
        m_gi[n] = fsat(fmul(m_gi[n], DI) + fsat(inh));
        m_it[n] = fsat(m_ge[n] - m_gi[n]);
        m_spk[n] = 1'b0;
        if (m_refr[n] > 0) begin
          m_v[n] = 0;
          m_refr[n]--;
        end else begin
          vn = fsat(fsat(0 + fmul(fsat(m_v[n] - 0), LEAK)) + m_it[n]);
          if (vn >= VTH) begin
            m_v[n] = 0; m_spk[n] = 1'b1; m_refr[n] = REFR; spike_total++;
          end else begin
            m_v[n] = vn;
          end
        end
      end
      if (cfg_we && int'(cfg_addr) < NS) begin
        if (cfg_sel_delay) m_d[cfg_addr] = (cfg_delay > 8'(MAXD)) ? MAXD : int'(cfg_delay);
        else               m_w[cfg_addr] = int'(cfg_wdata);
      end
    end
    model_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cfg_write(input int addr, input bit sel_d, input int val);
    cfg_we = 1'b1; cfg_sel_delay = sel_d; cfg_addr = AW'(addr);
    cfg_wdata = 16'(val); cfg_delay = 8'(val);
    tick();
    cfg_we = 1'b0;
  endtask

  // Compare DUT outputs against the model every cycle, away from posedge
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        for (int n = 0; n < NN; n++) begin
          check($sformatf("spike[%0d]", n), longint'(post_spikes[n]), longint'(m_spk[n]));
          check($sformatf("vmem[%0d]", n),  longint'(post_vmem[n]),   longint'(m_v[n]));
          check($sformatf("exc[%0d]", n),   longint'(dbg_exc[n]),     longint'(m_ge[n]));
          check($sformatf("inh[%0d]", n),   longint'(dbg_inh[n]),     longint'(m_gi[n]));
          check($sformatf("itot[%0d]", n),  longint'(dbg_i_total[n]), longint'(m_it[n]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; pre_spikes = '0; cfg_we = 1'b0; cfg_sel_delay = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; cfg_delay = '0;

    // Reset held for 10 cycles
    repeat (10) tick();
    check("rst_spikes", longint'(post_spikes), 0);
    for (int n = 0; n < NN; n++) begin
      check($sformatf("rst_vmem[%0d]", n), longint'(post_vmem[n]), 0);
      check($sformatf("rst_exc[%0d]", n),  longint'(dbg_exc[n]), 0);
      check($sformatf("rst_itot[%0d]", n), longint'(dbg_i_total[n]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Directed configuration
    cfg_write(0,  1'b0, 4096);    // n0,i0 w=1.0 d=0
    cfg_write(7,  1'b0, -2048);   // n1,i1 w=-0.5
    cfg_write(14, 1'b0, 4096);    // n2,i2 w=1.0
    cfg_write(21, 1'b0, 4096);    // n3,i3 w=1.0
    cfg_write(14, 1'b1, 3);       // n2,i2 d=3
    cfg_write(21, 1'b1, 9);       // n3,i3 d=9 -> clamped to 4
    repeat (3) tick();

    // Excitation with delay 0: spike right after the sampling edge
    pre_spikes = 6'b000001;
    tick();
    pre_spikes = '0;
    check("lit_exc0", longint'(dbg_exc[0]), 4096);
    check("lit_model_ge0", longint'(m_ge[0]), 4096);
    check("lit_spike0", longint'(post_spikes[0]), 1);
    check("lit_vmem0", longint'(post_vmem[0]), 0);
    for (int k = 0; k < REFR; k++) begin
      tick();
      check($sformatf("lit_refr0_%0d", k), longint'(post_spikes[0]), 0);
    end
    repeat (20) tick();

    // Inhibition: one pulse of w=-0.5, then decay by 0.88
    pre_spikes = 6'b000010;
    tick();
    pre_spikes = '0;
    check("lit_inh1", longint'(dbg_inh[1]), 2048);
    check("lit_itot1", longint'(dbg_i_total[1]), -2048);
    tick();
    check("lit_inh1_decay", longint'(dbg_inh[1]), 1802);
    check("lit_model_gi1", longint'(m_gi[1]), 1802);
    repeat (20) tick();

    // Delay 3 on n2 and clamped delay 4 on n3
    pre_spikes = 6'b001100;
    tick();
    pre_spikes = '0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lit_dly2_early%0d", k), longint'(post_spikes[2]), 0);
      tick();
    end
    check("lit_dly2_hit", longint'(post_spikes[2]), 1);
    check("lit_dly3_early", longint'(post_spikes[3]), 0);
    tick();
    check("lit_dly3_hit", longint'(post_spikes[3]), 1);
    repeat (10) tick();

    // Randomized phase: spikes, config writes (incl. out-of-range), resets
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < NI; i++) pre_spikes[i] = ($urandom_range(0, 3) == 0);
      cfg_we        = ($urandom_range(0, 5) == 0);
      cfg_sel_delay = 1'($urandom_range(0, 1));
      cfg_addr      = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) cfg_wdata = 16'($urandom);
      else                           cfg_wdata = 16'(int'($urandom_range(0, 6000)) - 2500);
      cfg_delay     = 8'($urandom_range(0, 12));
      tick();
    end
    rst_n = 1'b1; cfg_we = 1'b0; pre_spikes = '0;
    tick();
    check("spikes_seen", longint'(spike_total > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
